// File: rtl/sys_rst_req.sv
// Reset request generator. A keyed software write or an expired watchdog
// produces a fixed-width active-low reset pulse, followed by a holdoff window.
module sys_rst_req #(
  parameter int unsigned PULSE_CNT   = 16,
  parameter int unsigned HOLDOFF_CNT = 8,
  parameter int unsigned WDT_W       = 24,
  parameter logic [7:0]  KEY         = 8'hA5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             sw_wr_i,
  input  logic [31:0]      sw_wdata_i,
  input  logic             wdt_en_i,
  input  logic             wdt_kick_i,
  input  logic [WDT_W-1:0] wdt_load_i,
  output logic             rst_req_n_o,
  output logic             busy_o,
  output logic [1:0]       cause_o
);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

  localparam logic [7:0] PULSE_LAST   = 8'(PULSE_CNT - 1);
  localparam logic [7:0] HOLDOFF_LAST = 8'(HOLDOFF_CNT - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [WDT_W-1:0]   wdt_cnt_q, wdt_cnt_d;
  logic               wdt_en_q;
  logic               armed_q;
  logic               rst_req_n_q, rst_req_n_d;
  logic               busy_q, busy_d;
  logic [1:0]         cause_q, cause_d;

  logic               sw_req, wdt_req, wdt_reload_ext, wdt_reload_fsm;
  logic               unused_wdata;

  always_comb begin
    unused_wdata   = ^sw_wdata_i[23:0];
    sw_req         = sw_wr_i && (sw_wdata_i[31:24] == KEY);
    // A kick or enable rising edge reloads the counter and beats the zero condition.
    wdt_reload_ext = wdt_kick_i || (wdt_en_i && !wdt_en_q);
    wdt_req        = wdt_en_i && (wdt_cnt_q == '0) && !wdt_reload_ext;

    state_d        = state_q;
    cnt_d          = cnt_q;
    cause_d        = cause_q;
    wdt_reload_fsm = 1'b0;

    case (state_q)
      IDLE: begin
        if (armed_q && (sw_req || wdt_req)) begin
          state_d = ASSERT;
          cnt_d   = '0;
          cause_d = sw_req ? 2'b01 : 2'b10;
        end
      end
      ASSERT: begin
        if (cnt_q == PULSE_LAST) begin
          state_d        = HOLDOFF;
          cnt_d          = '0;
          wdt_reload_fsm = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLDOFF: begin
        if (cnt_q == HOLDOFF_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    wdt_cnt_d = wdt_cnt_q;
    if (wdt_reload_ext || wdt_reload_fsm) begin
      wdt_cnt_d = wdt_load_i;
    end else if (wdt_en_i && (state_q == IDLE) && (wdt_cnt_q != '0)) begin
      wdt_cnt_d = wdt_cnt_q - WDT_W'(1);
    end

    rst_req_n_d = (state_d != ASSERT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wdt_cnt_q   <= '0;
      wdt_en_q    <= 1'b0;
      armed_q     <= 1'b0;
      rst_req_n_q <= 1'b1;
      busy_q      <= 1'b0;
      cause_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_en_q    <= wdt_en_i;
      armed_q     <= 1'b1;
      rst_req_n_q <= rst_req_n_d;
      busy_q      <= busy_d;
      cause_q     <= cause_d;
    end
  end

  assign rst_req_n_o = rst_req_n_q;
  assign busy_o      = busy_q;
  assign cause_o     = cause_q;

endmodule

// File: tb/tb_sys_rst_req.sv
// Directed bench for sys_rst_req: software/watchdog requests, key filtering,
// kick race, holdoff drop and asynchronous reset mid-pulse.
module tb_sys_rst_req;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        sw_wr_i;
  logic [31:0] sw_wdata_i;
  logic        wdt_en_i;
  logic        wdt_kick_i;
  logic [23:0] wdt_load_i;
  logic        rst_req_n_o;
  logic        busy_o;
  logic [1:0]  cause_o;

  int n_checks = 0;
  int n_fail   = 0;
  int lo, bs, k;

  sys_rst_req #(.PULSE_CNT(16), .HOLDOFF_CNT(8), .WDT_W(24), .KEY(8'hA5)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .sw_wr_i     (sw_wr_i),
    .sw_wdata_i  (sw_wdata_i),
    .wdt_en_i    (wdt_en_i),
    .wdt_kick_i  (wdt_kick_i),
    .wdt_load_i  (wdt_load_i),
    .rst_req_n_o (rst_req_n_o),
    .busy_o      (busy_o),
    .cause_o     (cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits until rst_req_n_o falls; k ends as the count of posedges after the trigger edge.
  task automatic wait_fall(output int edges);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (rst_req_n_o && n < 400);
    edges = n - 1;
  endtask

  initial begin
    rst_n_i = 1'b0; sw_wr_i = 1'b0; sw_wdata_i = '0;
    wdt_en_i = 1'b0; wdt_kick_i = 1'b0; wdt_load_i = '0;

    repeat (2) @(negedge clk_i);
    chk("reset_rst_req_n", 32'(rst_req_n_o), 32'd1);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_cause", 32'(cause_o), 32'd0);
    chk("reset_wdt_cnt", 32'(dut.wdt_cnt_q), 32'd0);

    // Release with a valid write already present: the first edge must ignore it.
    rst_n_i = 1'b1; sw_wr_i = 1'b1; sw_wdata_i = 32'hA500_0000;
    @(negedge clk_i);
    sw_wr_i = 1'b0;
    chk("first_cycle_reject_rst", 32'(rst_req_n_o), 32'd1);
    chk("first_cycle_reject_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);

    sw_wr_i = 1'b1; sw_wdata_i = 32'hA500_0000;
    lo = 0; bs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (i == 0) begin
        sw_wr_i = 1'b0;
        chk("sw_first_low", 32'(rst_req_n_o), 32'd0);
        chk("sw_cause", 32'(cause_o), 32'd1);
        chk("sw_busy", 32'(busy_o), 32'd1);
      end
      lo += (rst_req_n_o == 1'b0) ? 1 : 0;
      bs += busy_o ? 1 : 0;
    end
    chk("sw_low_cycles", 32'(lo), 32'd16);
    chk("sw_busy_cycles", 32'(bs), 32'd24);

    sw_wr_i = 1'b1; sw_wdata_i = 32'h5A00_0000;
    @(negedge clk_i);
    sw_wr_i = 1'b0;
    chk("badkey_rst", 32'(rst_req_n_o), 32'd1);
    chk("badkey_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    chk("badkey_cause", 32'(cause_o), 32'd1);

    wdt_load_i = 24'd100; wdt_en_i = 1'b1;
    wait_fall(k);
    chk("wdt_latency", 32'(k), 32'd101);
    chk("wdt_cause", 32'(cause_o), 32'd2);
    repeat (16) @(negedge clk_i);
    chk("wdt_holdoff_busy", 32'(busy_o), 32'd1);
    chk("wdt_holdoff_rst", 32'(rst_req_n_o), 32'd1);
    chk("wdt_reload_on_holdoff", 32'(dut.wdt_cnt_q), 32'd100);
    wdt_en_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("wdt_idle_busy", 32'(busy_o), 32'd0);
    chk("wdt_hold_when_off", 32'(dut.wdt_cnt_q), 32'd100);

    wdt_load_i = 24'd0; wdt_en_i = 1'b1;
    wait_fall(k);
    chk("wdt_load0_latency", 32'(k), 32'd1);
    wdt_en_i = 1'b0;
    repeat (30) @(negedge clk_i);
    chk("wdt_load0_done", 32'(busy_o), 32'd0);

    wdt_load_i = 24'd5; wdt_en_i = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("kick_cnt_zero", 32'(dut.wdt_cnt_q), 32'd0);
    wdt_kick_i = 1'b1; wdt_load_i = 24'd7;
    @(negedge clk_i);
    wdt_kick_i = 1'b0; wdt_en_i = 1'b0;
    chk("kick_no_pulse", 32'(rst_req_n_o), 32'd1);
    chk("kick_no_busy", 32'(busy_o), 32'd0);
    chk("kick_reload", 32'(dut.wdt_cnt_q), 32'd7);
    repeat (3) @(negedge clk_i);
    chk("kick_still_idle", 32'(busy_o), 32'd0);

    wdt_load_i = 24'd3; wdt_en_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("sim_cnt_zero", 32'(dut.wdt_cnt_q), 32'd0);
    sw_wr_i = 1'b1; sw_wdata_i = 32'hA512_3456;
    lo = 0; bs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (i == 0) begin
        sw_wr_i = 1'b0;
        chk("sim_cause", 32'(cause_o), 32'd1);
      end
      if (i == 18) begin
        sw_wr_i = 1'b1; wdt_en_i = 1'b0;
      end
      if (i == 19) sw_wr_i = 1'b0;
      lo += (rst_req_n_o == 1'b0) ? 1 : 0;
      bs += busy_o ? 1 : 0;
    end
    chk("sim_low_cycles", 32'(lo), 32'd16);
    chk("sim_busy_cycles", 32'(bs), 32'd24);
    chk("sim_cause_final", 32'(cause_o), 32'd1);

    sw_wr_i = 1'b1; sw_wdata_i = 32'hA500_0000;
    @(negedge clk_i);
    sw_wr_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("midrst_pre_low", 32'(rst_req_n_o), 32'd0);
    #2 rst_n_i = 1'b0;
    #1;
    chk("midrst_async_rst", 32'(rst_req_n_o), 32'd1);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_cause", 32'(cause_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("post_rst_idle_rst", 32'(rst_req_n_o), 32'd1);
    chk("post_rst_idle_busy", 32'(busy_o), 32'd0);
    sw_wr_i = 1'b1;
    @(negedge clk_i);
    sw_wr_i = 1'b0;
    chk("post_rst_accept", 32'(rst_req_n_o), 32'd0);
    repeat (30) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_rst_req.md
SYS_RST_REQ -- requirements
Module: sys_rst_req

Interface
REQ-001 Parameter PULSE_CNT, default 16: number of clk_i cycles rst_req_n_o is held low per request (legal range 1..255).
REQ-002 Parameter HOLDOFF_CNT, default 8: number of clk_i cycles after the pulse during which new requests are ignored (legal range 1..255).
REQ-003 Parameter WDT_W, default 24: watchdog counter width.
REQ-004 Parameter KEY, default 8'hA5: software request key.
REQ-005 clk_i  input  1  system clock; all logic is in this single domain.
REQ-006 rst_n_i  input  1  asynchronous, active-low reset.
REQ-007 sw_wr_i  input  1  single-cycle software write strobe.
REQ-008 sw_wdata_i  input  32  software write data; bits [31:24] carry the key.
REQ-009 wdt_en_i  input  1  watchdog enable (level).
REQ-010 wdt_kick_i  input  1  watchdog reload strobe.
REQ-011 wdt_load_i  input  WDT_W  watchdog reload value, sampled at every reload.
REQ-012 rst_req_n_o  output  1  registered active-low reset request, driven to the reset generator's rst_n_i.
REQ-013 busy_o  output  1  high in the ASSERT and HOLDOFF states.
REQ-014 cause_o  output  2  last request cause: 00 = none, 01 = software, 10 = watchdog.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ASSERT and HOLDOFF.
REQ-016 A software request SHALL be sw_wr_i=1 with sw_wdata_i[31:24]==KEY; a write with any other key value SHALL be ignored with no side effects.
REQ-017 A watchdog request SHALL be wdt_en_i=1 with the watchdog counter equal to 0.
REQ-018 IDLE -> ASSERT SHALL occur on the clock edge at which a request is present; rst_req_n_o SHALL go low at that edge (one-cycle latency from request to output).
REQ-019 On the IDLE -> ASSERT edge, cause_o SHALL be updated to 01 for a software request or 10 for a watchdog request.
REQ-020 If software and watchdog requests occur in the same cycle, software SHALL win (cause_o=01).
REQ-021 In ASSERT, rst_req_n_o SHALL remain low for exactly PULSE_CNT cycles, after which the FSM SHALL move to HOLDOFF and rst_req_n_o SHALL return high.
REQ-022 HOLDOFF SHALL last exactly HOLDOFF_CNT cycles and then return to IDLE.
REQ-023 Requests arriving in ASSERT or HOLDOFF SHALL be dropped, not queued.
REQ-024 The watchdog counter SHALL reload from wdt_load_i on a wdt_kick_i pulse and on a rising edge of wdt_en_i.
REQ-025 The watchdog counter SHALL otherwise decrement by 1 per cycle while wdt_en_i=1 and the state is IDLE, saturating at 0 with no wrap.
REQ-026 If a kick and the zero condition coincide, the kick SHALL win and no request SHALL be raised.
REQ-027 With wdt_en_i=0 the watchdog counter SHALL hold its value and SHALL never raise a request.
REQ-028 On the ASSERT -> HOLDOFF transition the watchdog counter SHALL reload from wdt_load_i, so an expired watchdog does not retrigger immediately.
REQ-029 wdt_load_i=0 with wdt_en_i=1 SHALL raise a request on the first IDLE cycle after the reload.
REQ-030 The pulse and holdoff counters SHALL be 8 bits wide and SHALL be cleared on every state entry.

Reset
REQ-031 Asserting rst_n_i low SHALL asynchronously force: state=IDLE, rst_req_n_o=1, busy_o=0, cause_o=00, watchdog counter=0, pulse/holdoff counters=0, wdt_en_i edge-detect register=0.
REQ-032 Reset asserted mid-ASSERT SHALL abort the pulse immediately, driving rst_req_n_o high asynchronously.
REQ-033 Deassertion of rst_n_i SHALL be synchronous to clk_i, and no request SHALL be accepted in the first cycle after release.
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Software request: sw_wr_i with 0xA5000000 in IDLE -> rst_req_n_o low for exactly 16 cycles starting next edge, cause_o=01, busy_o high for 24 cycles.
REQ-036 Bad key: sw_wr_i with 0x5A000000 -> rst_req_n_o stays 1, cause_o unchanged, state IDLE.
REQ-037 Watchdog: wdt_load_i=100, wdt_en_i rises, no kicks -> rst_req_n_o falls 101 cycles after the enable edge, cause_o=10.
REQ-038 Kick race: kick on the cycle the counter reaches 0 -> no pulse, counter reloads to wdt_load_i.
REQ-039 Simultaneous events: valid software write with watchdog at 0 -> a single 16-cycle pulse with cause_o=01; a second write during HOLDOFF -> ignored.
REQ-040 Reset mid-pulse: rst_n_i low at pulse cycle 5 -> rst_req_n_o=1 asynchronously, cause_o=00, FSM in IDLE after release.
